// File: rtl/edge_period_meter.sv
// Measures the clk-cycle interval between consecutive edge pulses and hands each
// period downstream through a single registered valid/ready holding stage.
module edge_period_meter #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              edge_pulse,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  input  logic              period_ready,
  output logic              timeout,
  output logic [DROP_W-1:0] drop_cnt
);

  // state      | meaning
  // IDLE       | disabled, counter held at 0, edges ignored
  // WAIT_FIRST | armed, waiting for the reference edge (not reported)
  // MEASURE    | counting cycles since the last edge, each edge reports

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             capture;
  logic             timeout_nxt;
  logic             load;
  logic             drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    capture     = 1'b0;
    timeout_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (edge_pulse) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = MEASURE;
          end else begin
            cnt_nxt = '0;
          end
        end
        MEASURE: begin
          // An edge landing on the terminal count wins over the timeout.
          if (edge_pulse) begin
            capture = 1'b1;
            cnt_nxt = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            timeout_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = WAIT_FIRST;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign load = capture & (~period_valid | period_ready);
  assign drop = capture & period_valid & ~period_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      timeout <= timeout_nxt;
      if (load) begin
        period       <= cnt;
        period_valid <= 1'b1;
      end else if (period_ready) begin
        period_valid <= 1'b0;
      end
      if (drop && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + DROP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_edge_period_meter.sv
// Directed bench for edge_period_meter: a 16-bit instance for measurement and
// handshake behaviour, an 8-bit instance sharing the stimulus for timeout cases.
module tb_edge_period_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        edge_pulse;
  logic        period_ready;

  logic [15:0] period16;
  logic        valid16;
  logic        timeout16;
  logic [7:0]  drop16;

  logic [7:0]  period8;
  logic        valid8;
  logic        timeout8;
  logic [7:0]  drop8;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  edge_period_meter #(.CNT_W(16), .DROP_W(8)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .edge_pulse(edge_pulse),
    .period(period16), .period_valid(valid16), .period_ready(period_ready),
    .timeout(timeout16), .drop_cnt(drop16)
  );

  edge_period_meter #(.CNT_W(8), .DROP_W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .edge_pulse(edge_pulse),
    .period(period8), .period_valid(valid8), .period_ready(period_ready),
    .timeout(timeout8), .drop_cnt(drop8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    edge_pulse = 1'b1;
    tick();
    edge_pulse = 1'b0;
  endtask

  // Drop to IDLE then re-arm so the next edge is a fresh reference edge.
  task automatic rearm();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    edge_pulse   = 1'b0;
    period_ready = 1'b0;
    idle(2);
    chk("rst_period", period16, 0);
    chk("rst_valid", valid16, 0);
    chk("rst_timeout", timeout16, 0);
    chk("rst_drop", drop16, 0);
    reset = 1'b0;

    // Normal measurement: edges 100 then 50 cycles apart.
    enable       = 1'b1;
    period_ready = 1'b1;
    tick();
    pulse();
    chk("first_edge_silent", valid16, 0);
    idle(99);
    pulse();
    chk("p100_valid", valid16, 1);
    chk("p100_value", period16, 100);
    idle(1);
    chk("p100_accepted", valid16, 0);
    chk("p100_kept", period16, 100);
    idle(48);
    pulse();
    chk("p50_valid", valid16, 1);
    chk("p50_value", period16, 50);

    // Back-to-back pulses after a fresh arm.
    rearm();
    pulse();
    chk("b2b_first_silent", valid16, 0);
    pulse();
    chk("b2b_1_valid", valid16, 1);
    chk("b2b_1_value", period16, 1);
    pulse();
    chk("b2b_2_valid", valid16, 1);
    chk("b2b_2_value", period16, 1);
    idle(1);
    chk("b2b_drained", valid16, 0);

    // Back-pressure: edges at 0, 10, 30, 45 with ready low.
    rearm();
    period_ready = 1'b0;
    pulse();
    idle(9);
    pulse();
    chk("bp_p10_valid", valid16, 1);
    chk("bp_p10_value", period16, 10);
    idle(19);
    pulse();
    chk("bp_drop1", drop16, 1);
    chk("bp_hold1", period16, 10);
    idle(14);
    pulse();
    chk("bp_drop2", drop16, 2);
    chk("bp_hold2", period16, 10);
    chk("bp_hold_valid", valid16, 1);
    period_ready = 1'b1;
    tick();
    period_ready = 1'b0;
    chk("bp_accept", valid16, 0);
    idle(13);
    pulse();
    chk("bp_p15_valid", valid16, 1);
    chk("bp_p15_value", period16, 15);
    chk("bp_drop_stable", drop16, 2);

    // Enable interaction: edges while disabled are ignored.
    period_ready = 1'b1;
    tick();
    enable = 1'b0;
    pulse();
    pulse();
    chk("dis_no_report", valid16, 0);
    enable = 1'b1;
    tick();
    pulse();
    chk("reen_first_silent", valid16, 0);
    idle(4);
    period_ready = 1'b0;
    pulse();
    chk("reen_p5_valid", valid16, 1);
    chk("reen_p5_value", period16, 5);
    enable = 1'b0;
    idle(2);
    chk("dis_keeps_valid", valid16, 1);
    chk("dis_keeps_period", period16, 5);

    // Timeout on the 8-bit instance.
    do_reset();
    enable       = 1'b1;
    period_ready = 1'b1;
    tick();
    pulse();
    idle(254);
    chk("to_not_yet", timeout8, 0);
    idle(1);
    chk("to_pulse", timeout8, 1);
    chk("to_no_report", valid8, 0);
    idle(1);
    chk("to_single", timeout8, 0);
    pulse();
    chk("to_rearm_silent", valid8, 0);
    idle(6);
    pulse();
    chk("to_p7_valid", valid8, 1);
    chk("to_p7_value", period8, 7);
    idle(254);
    pulse();
    chk("max_valid", valid8, 1);
    chk("max_value", period8, 255);
    chk("max_no_timeout", timeout8, 0);
    idle(1);
    chk("max_no_timeout_next", timeout8, 0);

    // Asynchronous reset with a held period and drop_cnt=3.
    do_reset();
    enable       = 1'b1;
    period_ready = 1'b0;
    tick();
    pulse();
    idle(2);
    pulse();
    chk("ar_p3_value", period16, 3);
    pulse();
    pulse();
    pulse();
    chk("ar_drop3", drop16, 3);
    chk("ar_valid_before", valid16, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_period", period16, 0);
    chk("ar_valid", valid16, 0);
    chk("ar_timeout", timeout16, 0);
    chk("ar_drop", drop16, 0);
    idle(2);
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/edge_period_meter.md
Name: edge_period_meter

Overview:
- Consumes the single-cycle rising-edge pulses produced by the input edge-detect stage.
- Measures the interval between consecutive edges in clk cycles.
- Presents each measured period to downstream logic through a registered valid/ready output.
- Flags timeouts when no edge arrives within the counter range, and counts measurements lost to back-pressure.

Parameters:
CNT_W, 16, width of the period counter and period output; MAX = 2^CNT_W-1
DROP_W, 8, width of the dropped-measurement counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  measurement enable; 0 forces IDLE
edge_pulse  in  1  single-cycle rising-edge indication from the edge detector
period  out  CNT_W  measured interval in clk cycles, valid when period_valid=1
period_valid  out  1  output holding register full
period_ready  in  1  downstream accepts period when period_valid & period_ready
timeout  out  1  one-cycle pulse: counter reached MAX with no edge
drop_cnt  out  DROP_W  saturating count of periods discarded because the output register was occupied

Behaviour:
Reset (asynchronous, reset=1):
- state=IDLE, counter=0, period=0, period_valid=0, timeout=0, drop_cnt=0.

State machine (3 states, registered):
- IDLE:
  - Counter held at 0; edge_pulse ignored.
  - enable=1 -> WAIT_FIRST on next clock.
- WAIT_FIRST:
  - edge_pulse=1 -> counter<=1, go MEASURE.
  - Nothing is reported for the first edge.
- MEASURE:
  - Counter increments by 1 each cycle.
  - On edge_pulse=1: capture period=counter and reload counter<=1 in the same cycle; stay in MEASURE.
  - On counter==MAX with edge_pulse=0: timeout=1 for the next cycle only, counter<=0, go WAIT_FIRST; no period reported.
  - On counter==MAX with edge_pulse=1: report period=MAX as a normal measurement; no timeout.
- Any state:
  - enable=0 -> IDLE on next clock, counter<=0.
  - An edge_pulse sampled while enable=0 is ignored.
  - An already-held period_valid/period pair is not cleared by enable=0; it remains until accepted.

Period arithmetic:
- Edges sampled at clock edges k0 and k1 give period=k1-k0.
- Back-to-back pulses give period=1; the minimum reportable value is 1.
- The counter never wraps; MAX is the terminal value.

Output handshake:
- Capture loads the output register when period_valid=0 or period_ready=1 in the capture cycle.
- Load makes period_valid=1 on the next cycle (latency 1 clock from the sampled edge to period_valid).
- Simultaneous accept and capture: the new value loads and period_valid stays 1 with no bubble.
- Accept without capture: period_valid<=0; period keeps its last value.
- Capture while period_valid=1 and period_ready=0: the new measurement is dropped, drop_cnt increments and saturates at 2^DROP_W-1, and the held period is unchanged.
- period and period_valid are stable while period_valid=1 and period_ready=0.

Reset mid-operation:
- All state is cleared immediately, including a pending output and drop_cnt.
- Measurement restarts from IDLE after reset deasserts.

Test Plan:
- Normal measurement (CNT_W=16): enable=1, period_ready=1, edge_pulse at cycles 10, 110, 160 -> period_valid pulses at cycles 111 and 161 with period=100 then 50; nothing reported after the first edge.
- Back-to-back pulses: edge_pulse high at cycles 20, 21, 22 -> two reports, both period=1.
- Back-pressure: period_ready=0, edges at 0, 10, 30, 45 -> period=10 held valid; drop_cnt=2. Then period_ready=1 for one cycle -> accepted; next edge at 60 reports period=15.
- Timeout (CNT_W=8):
  - First edge at cycle 0, no further edge -> timeout pulses exactly once, one cycle after the counter reaches 255.
  - State returns to WAIT_FIRST; the next two edges 7 cycles apart report period=7.
  - Edge arriving exactly at counter==255 -> period=255 reported, no timeout.
- Enable and reset interaction:
  - enable drops between edges -> no report, and edges during enable=0 are ignored.
  - After re-enable, the first edge is again unreported.
  - reset=1 asynchronously while period_valid=1 and drop_cnt=3 -> all outputs 0 immediately, without waiting for clk.
